// File: rtl/adc_scan_pkg.sv
// Shared encodings and widths for the ADC channel scanner.
// The optional handshake watchdog is enabled by defining ADC_SCAN_TIMEOUT_EN.
package adc_scan_pkg;

    localparam int ADC_CODE_W = 16;
    localparam int VOLT_W     = 12;

    typedef enum logic [2:0] {
        TRIGGER    = 3'd0,
        WAIT_START = 3'd1,
        WAIT_DONE  = 3'd2,
        ACCUM      = 3'd3,
        PUBLISH    = 3'd4
    } scan_state_t;

    // Negative averages clamp to zero; otherwise drop the sign bit and the 3 LSBs.
    function automatic logic [VOLT_W-1:0] volt_from_avg(input logic [ADC_CODE_W-1:0] avg);
        return avg[ADC_CODE_W-1] ? '0 : avg[14:3];
    endfunction

endpackage

// File: rtl/adc_sample_accumulator.sv
// Signed sample accumulator with floor-shift averaging and the clamped display slice.
// Part of adc_channel_scanner (optional watchdog macro: ADC_SCAN_TIMEOUT_EN, handled in the top).
module adc_sample_accumulator
    import adc_scan_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clear,
    input  logic                  i_add,
    input  logic [ADC_CODE_W-1:0] i_sample,
    output logic [ADC_CODE_W-1:0] o_avg,
    output logic [VOLT_W-1:0]     o_volt
);

    localparam int ACC_W = ADC_CODE_W + AVG_LOG2;

    logic signed [ACC_W-1:0]      r_acc;
    logic signed [ADC_CODE_W-1:0] w_sample_s;
    logic signed [ACC_W-1:0]      w_sample_ext;

    assign w_sample_s   = i_sample;
    assign w_sample_ext = ACC_W'(w_sample_s);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_add) begin
            r_acc <= r_acc + w_sample_ext;
        end
    end

    // Arithmetic shift floors toward -inf, so -33/4 becomes -9.
    assign o_avg  = ADC_CODE_W'(r_acc >>> AVG_LOG2);
    assign o_volt = volt_from_avg(o_avg);

endmodule

// File: rtl/adc_channel_scanner.sv
// Round-robin ADC channel scanner: runs the adcEnable/adcDataReady handshake,
// averages 2^AVG_LOG2 samples per channel and publishes raw and display values.
// Define ADC_SCAN_TIMEOUT_EN to add the sticky handshake watchdog.
module adc_channel_scanner
    import adc_scan_pkg::*;
#(
    parameter int          NUM_CHANNELS   = 2,
    parameter int          AVG_LOG2       = 2,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2700000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           adcDataReady,
    input  logic [ADC_CODE_W-1:0]          adcOutputData,
    output logic                           adcEnable,
    output logic [1:0]                     adcChannel,
    output logic [16*NUM_CHANNELS-1:0]     rawAvg,
    output logic [12*NUM_CHANNELS-1:0]     voltage,
    output logic                           sampleValid,
    output logic [1:0]                     sampleChannel,
    output logic                           timeoutError,
    output logic [2:0]                     o_dbg_state
);

    // Handshake: adcEnable is a level request; the adc acknowledges start by
    // dropping adcDataReady and completion by raising it with valid data.
    localparam logic [4:0] SAMPLES = 5'(1 << AVG_LOG2);

    scan_state_t           r_state;
    logic [ADC_CODE_W-1:0] r_sample;
    logic [4:0]            r_count;
    logic [ADC_CODE_W-1:0] w_avg;
    logic [VOLT_W-1:0]     w_volt;
    logic                  w_timeout;
    logic                  w_acc_clear;
    logic                  w_acc_add;

    assign o_dbg_state = r_state;
    assign w_acc_add   = (r_state == ACCUM) && !w_timeout;
    assign w_acc_clear = (r_state == PUBLISH) || w_timeout;

    adc_sample_accumulator #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_acc (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_acc_clear),
        .i_add    (w_acc_add),
        .i_sample (r_sample),
        .o_avg    (w_avg),
        .o_volt   (w_volt)
    );

`ifdef ADC_SCAN_TIMEOUT_EN
    logic [31:0] r_wd;
    logic        w_waiting;
    logic        w_leave;

    assign w_waiting = (r_state == WAIT_START) || (r_state == WAIT_DONE);
    assign w_leave   = ((r_state == WAIT_START) && !adcDataReady) ||
                       ((r_state == WAIT_DONE) && adcDataReady);
    assign w_timeout = w_waiting && (r_wd == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd         <= '0;
            timeoutError <= 1'b0;
        end else begin
            if (w_timeout) begin
                timeoutError <= 1'b1;
            end
            if (!w_waiting || w_leave || w_timeout) begin
                r_wd <= '0;
            end else begin
                r_wd <= r_wd + 32'd1;
            end
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
    assign timeoutError     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= TRIGGER;
            r_sample      <= '0;
            r_count       <= '0;
            adcEnable     <= 1'b0;
            adcChannel    <= '0;
            rawAvg        <= '0;
            voltage       <= '0;
            sampleValid   <= 1'b0;
            sampleChannel <= '0;
        end else begin
            sampleValid <= 1'b0;
            if (w_timeout) begin
                // Abandon this channel's partial average and retry it.
                adcEnable <= 1'b0;
                r_count   <= '0;
                r_state   <= TRIGGER;
            end else begin
                case (r_state)
                    TRIGGER: begin
                        adcEnable <= 1'b1;
                        r_state   <= WAIT_START;
                    end
                    WAIT_START: begin
                        if (!adcDataReady) r_state <= WAIT_DONE;
                    end
                    WAIT_DONE: begin
                        if (adcDataReady) begin
                            r_sample  <= adcOutputData;
                            adcEnable <= 1'b0;
                            r_state   <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        r_count <= r_count + 5'd1;
                        r_state <= (r_count + 5'd1 == SAMPLES) ? PUBLISH : TRIGGER;
                    end
                    PUBLISH: begin
                        for (int n = 0; n < NUM_CHANNELS; n++) begin
                            if (adcChannel == 2'(n)) begin
                                rawAvg[16*n +: 16]  <= w_avg;
                                voltage[12*n +: 12] <= w_volt;
                            end
                        end
                        sampleValid   <= 1'b1;
                        sampleChannel <= adcChannel;
                        r_count       <= '0;
                        adcChannel    <= (adcChannel == 2'(NUM_CHANNELS - 1)) ? 2'd0 : adcChannel + 2'd1;
                        r_state       <= TRIGGER;
                    end
                    default: r_state <= TRIGGER;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_channel_scanner.sv
// Directed bench: two scanner instances (3ch/avg4 with short watchdog, 2ch/no averaging),
// each driven by a behavioural adc model and checked by a publish scoreboard.
module tb_adc_channel_scanner;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_errors;

    // instance a: NUM_CHANNELS=3, AVG_LOG2=2, TIMEOUT_CYCLES=50
    logic        a_rdy, a_en, a_sv, a_to;
    logic [15:0] a_data;
    logic [1:0]  a_ch, a_schan;
    logic [47:0] a_raw;
    logic [35:0] a_volt;
    logic [2:0]  a_dbg;
    // instance b: NUM_CHANNELS=2, AVG_LOG2=0
    logic        b_rdy, b_en, b_sv, b_to;
    logic [15:0] b_data;
    logic [1:0]  b_ch, b_schan;
    logic [31:0] b_raw;
    logic [23:0] b_volt;
    logic [2:0]  b_dbg;

    logic [15:0] a_samp_q[$];
    logic [15:0] b_samp_q[$];
    logic [29:0] exp_qa[$];   // {channel, raw, volt}
    logic [29:0] exp_qb[$];

    int a_phase, a_cnt, a_delivered, a_rdy_cyc, a_last, pub_a;
    int b_phase, b_cnt, b_delivered, b_rdy_cyc, b_last, pub_b;
    logic a_prev_sv, a_prev_en;
    logic b_prev_sv, b_prev_en;
    logic [1:0] a_prev_ch, b_prev_ch;

    adc_channel_scanner #(
        .NUM_CHANNELS   (3),
        .AVG_LOG2       (2),
        .TIMEOUT_CYCLES (32'd50)
    ) u_dut_a (
        .clk           (clk),
        .reset         (reset),
        .adcDataReady  (a_rdy),
        .adcOutputData (a_data),
        .adcEnable     (a_en),
        .adcChannel    (a_ch),
        .rawAvg        (a_raw),
        .voltage       (a_volt),
        .sampleValid   (a_sv),
        .sampleChannel (a_schan),
        .timeoutError  (a_to),
        .o_dbg_state   (a_dbg)
    );

    adc_channel_scanner #(
        .NUM_CHANNELS (2),
        .AVG_LOG2     (0)
    ) u_dut_b (
        .clk           (clk),
        .reset         (reset),
        .adcDataReady  (b_rdy),
        .adcOutputData (b_data),
        .adcEnable     (b_en),
        .adcChannel    (b_ch),
        .rawAvg        (b_raw),
        .voltage       (b_volt),
        .sampleValid   (b_sv),
        .sampleChannel (b_schan),
        .timeoutError  (b_to),
        .o_dbg_state   (b_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // adc model a: ready drops 3 cycles after enable, rises 20 cycles later with data
    initial begin
        a_rdy = 1'b1; a_data = '0; a_phase = 0; a_cnt = 0; a_delivered = 0; a_rdy_cyc = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                a_phase = 0; a_rdy = 1'b1; a_delivered = 0;
            end else if (a_phase == 0) begin
                if (a_en && a_samp_q.size() > 0) begin a_phase = 1; a_cnt = 0; end
            end else begin
                a_cnt++;
                if (a_phase == 1 && a_cnt == 3) begin
                    a_rdy = 1'b0; a_phase = 2; a_cnt = 0;
                end else if (a_phase == 2 && a_cnt == 20) begin
                    a_data = a_samp_q.pop_front(); a_rdy = 1'b1; a_phase = 0;
                    a_delivered++; a_rdy_cyc = cyc;
                end
            end
        end
    end

    // adc model b
    initial begin
        b_rdy = 1'b1; b_data = '0; b_phase = 0; b_cnt = 0; b_delivered = 0; b_rdy_cyc = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                b_phase = 0; b_rdy = 1'b1; b_delivered = 0;
            end else if (b_phase == 0) begin
                if (b_en && b_samp_q.size() > 0) begin b_phase = 1; b_cnt = 0; end
            end else begin
                b_cnt++;
                if (b_phase == 1 && b_cnt == 3) begin
                    b_rdy = 1'b0; b_phase = 2; b_cnt = 0;
                end else if (b_phase == 2 && b_cnt == 20) begin
                    b_data = b_samp_q.pop_front(); b_rdy = 1'b1; b_phase = 0;
                    b_delivered++; b_rdy_cyc = cyc;
                end
            end
        end
    end

    // scoreboard / monitor a
    initial begin
        logic [29:0] e;
        int c;
        pub_a = 0; a_last = 0; a_prev_sv = 1'b0; a_prev_en = 1'b0; a_prev_ch = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                a_last = 0;
            end else begin
                if (a_en && a_prev_en) check_eq("a_ch_stable", a_ch, a_prev_ch);
                if (a_sv) begin
                    check_eq("a_sv_pulse", a_prev_sv, 0);
                    check_eq("a_samples_per_pub", a_delivered - a_last, 4);
                    check_eq("a_latency", cyc - a_rdy_cyc, 3);
                    a_last = a_delivered;
                    check_eq("a_exp_avail", exp_qa.size() > 0, 1);
                    if (exp_qa.size() > 0) begin
                        e = exp_qa.pop_front();
                        c = int'(e[29:28]);
                        check_eq("a_schan", a_schan, e[29:28]);
                        check_eq("a_raw", a_raw[16*c +: 16], e[27:12]);
                        check_eq("a_volt", a_volt[12*c +: 12], e[11:0]);
                    end
                    pub_a++;
                end
            end
            a_prev_sv = a_sv; a_prev_en = a_en; a_prev_ch = a_ch;
        end
    end

    // scoreboard / monitor b
    initial begin
        logic [29:0] e;
        int c;
        pub_b = 0; b_last = 0; b_prev_sv = 1'b0; b_prev_en = 1'b0; b_prev_ch = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                b_last = 0;
            end else begin
                if (b_en && b_prev_en) check_eq("b_ch_stable", b_ch, b_prev_ch);
                if (b_sv) begin
                    check_eq("b_sv_pulse", b_prev_sv, 0);
                    check_eq("b_samples_per_pub", b_delivered - b_last, 1);
                    check_eq("b_latency", cyc - b_rdy_cyc, 3);
                    b_last = b_delivered;
                    check_eq("b_exp_avail", exp_qb.size() > 0, 1);
                    if (exp_qb.size() > 0) begin
                        e = exp_qb.pop_front();
                        c = int'(e[29:28]);
                        check_eq("b_schan", b_schan, e[29:28]);
                        check_eq("b_raw", b_raw[16*c +: 16], e[27:12]);
                        check_eq("b_volt", b_volt[12*c +: 12], e[11:0]);
                    end
                    pub_b++;
                end
            end
            b_prev_sv = b_sv; b_prev_en = b_en; b_prev_ch = b_ch;
        end
    end

    task automatic wait_pub(input int which, input int target, input string tag);
        int n;
        n = 0;
        while (((which == 0) ? pub_a : pub_b) < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, ((which == 0) ? pub_a : pub_b) >= target, 1);
    endtask

    task automatic check_a_zero(input string tag);
        check_eq({tag, "_a_en"}, a_en, 0);
        check_eq({tag, "_a_ch"}, a_ch, 0);
        check_eq({tag, "_a_raw"}, a_raw, 0);
        check_eq({tag, "_a_volt"}, a_volt, 0);
        check_eq({tag, "_a_sv"}, a_sv, 0);
        check_eq({tag, "_a_schan"}, a_schan, 0);
        check_eq({tag, "_a_to"}, a_to, 0);
        check_eq({tag, "_b_en"}, b_en, 0);
        check_eq({tag, "_b_raw"}, b_raw, 0);
        check_eq({tag, "_b_sv"}, b_sv, 0);
    endtask

    // driver / directed sequence
    initial begin
        int n;
        n_checks = 0; n_errors = 0;
        reset = 1'b1;
        // a: ch0 avg of 100,101,102,104 = 101; ch1 -8,-8,-8,-9 -> floor -9; ch2 4000
        a_samp_q = '{16'd100, 16'd101, 16'd102, 16'd104,
                     16'hFFF8, 16'hFFF8, 16'hFFF8, 16'hFFF7,
                     16'd4000, 16'd4000, 16'd4000, 16'd4000,
                     16'd1000, 16'd1000, 16'd1000, 16'd1000};
        exp_qa.push_back({2'd0, 16'h0065, 12'h00C});
        exp_qa.push_back({2'd1, 16'hFFF7, 12'h000});
        exp_qa.push_back({2'd2, 16'h0FA0, 12'h1F4});
        // b: no averaging; clamp and full-scale cases
        b_samp_q = '{16'h2000, 16'h8000, 16'h7FFF, 16'h0008};
        exp_qb.push_back({2'd0, 16'h2000, 12'h400});
        exp_qb.push_back({2'd1, 16'h8000, 12'h000});
        exp_qb.push_back({2'd0, 16'h7FFF, 12'hFFF});
        exp_qb.push_back({2'd1, 16'h0008, 12'h001});

        repeat (3) @(negedge clk);
        #1 check_a_zero("reset_state");
        #2 reset = 1'b0;

        wait_pub(1, 1, "b_first_pub");
        n = 0;
        while (!b_en && n < 200) begin @(negedge clk); n++; end
        check_eq("b_next_conv_en", b_en, 1);
        check_eq("b_next_conv_ch", b_ch, 1);

        wait_pub(0, 3, "a_three_pubs");
        check_eq("a_ch_wrap", a_ch, 0);
        wait_pub(1, 4, "b_four_pubs");
        check_eq("b_raw_hold", b_raw, 32'h0008_7FFF);
        check_eq("b_volt_hold", b_volt, 24'h001_FFF);

        // reset while instance a is mid-average (second ch0 conversion, WAIT_DONE)
        n = 0;
        while (!(a_delivered == 13 && a_phase == 2) && n < 1000) begin @(negedge clk); n++; end
        @(negedge clk);
        check_eq("a_mid_conv_en", a_en, 1);
        #2 reset = 1'b1;
        #1 check_a_zero("async_reset");
        a_samp_q.delete();
        exp_qa.delete();
        repeat (2) @(negedge clk);
        a_samp_q = '{16'd8, 16'd8, 16'd8, 16'd8};
        exp_qa.push_back({2'd0, 16'h0008, 12'h001});
        #3 reset = 1'b0;
        wait_pub(0, 4, "a_post_reset_pub");
        check_eq("a_post_reset_upper", a_raw[47:16], 0);
        check_eq("a_post_reset_ch", a_ch, 1);
        check_eq("a_to_clear", a_to, 0);

`ifdef ADC_SCAN_TIMEOUT_EN
        begin
            int dur;
            n = 0;
            while (!a_en && n < 200) begin @(negedge clk); n++; end
            dur = 0;
            while (a_en && dur < 500) begin @(negedge clk); dur++; end
            check_eq("a_timeout_dur", dur, 50);
            check_eq("a_timeout_flag", a_to, 1);
            n = 0;
            while (!a_en && n < 200) begin @(negedge clk); n++; end
            check_eq("a_retry_en", a_en, 1);
            check_eq("a_retry_ch", a_ch, 1);
            a_samp_q = '{16'd8, 16'd8, 16'd8, 16'd8};
            exp_qa.push_back({2'd1, 16'h0008, 12'h001});
            wait_pub(0, 5, "a_retry_pub");
            check_eq("a_timeout_sticky", a_to, 1);
        end
`else
        repeat (100) @(negedge clk);
        check_eq("a_to_tied", a_to, 0);
`endif
        check_eq("b_to_idle", b_to, 0);
        check_eq("a_exp_drained", exp_qa.size(), 0);
        check_eq("b_exp_drained", exp_qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_channel_scanner.md
Name: adc_channel_scanner

Overview:
- Sits between the ADS1115 `adc` driver and the display/decimal stage (`toDec`, hex converters) in top.
- Round-robins the ADC input channel and runs the adcEnable/adcDataReady handshake per conversion.
- Averages 2^AVG_LOG2 signed samples per channel, then publishes a per-channel averaged raw code and a clamped 12-bit display value.
- Replaces the ad-hoc trigger/save logic in top with a reusable, resettable block.

Parameters:
- NUM_CHANNELS, 2: channels scanned, 0..NUM_CHANNELS-1; legal 1..4.
- AVG_LOG2, 2: log2 of samples averaged per channel; legal 0..4; 0 means no averaging.
- TIMEOUT_CYCLES, 32'd2700000: watchdog limit per handshake phase; used only with ADC_SCAN_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- adcDataReady  in  1  from adc; low = conversion in progress, high = idle/result valid.
- adcOutputData  in  16  from adc; signed two's-complement conversion result.
- adcEnable  out  1  to adc; request conversion.
- adcChannel  out  2  to adc; channel select.
- rawAvg  out  16*NUM_CHANNELS  averaged signed code; channel n at [16n+:16].
- voltage  out  12*NUM_CHANNELS  display value for toDec; channel n at [12n+:12].
- sampleValid  out  1  one-cycle pulse when a channel's outputs update.
- sampleChannel  out  2  channel updated on the sampleValid cycle.
- timeoutError  out  1  sticky watchdog flag; tied 0 when the feature is off.

Behaviour:
- Reset values, applied immediately on async reset: all outputs 0; FSM in TRIGGER; accumulator, sample counter and watchdog cleared.
- Reset mid-conversion drops adcEnable at once. No partial average is ever published.
- FSM states:
  - TRIGGER: adcEnable<=1 -> WAIT_START.
  - WAIT_START: stay until adcDataReady==0 -> WAIT_DONE.
  - WAIT_DONE: on adcDataReady==1, latch adcOutputData into ACC and set adcEnable<=0 in the same edge -> ACCUM.
  - ACCUM: sign-extend the sample and add it to the accumulator (width 16+AVG_LOG2, signed); count++.
    - If count reaches 2^AVG_LOG2 -> PUBLISH.
    - Otherwise -> TRIGGER.
  - PUBLISH:
    - rawAvg[ch] <= acc >>> AVG_LOG2 (arithmetic shift, floor toward -inf).
    - voltage[ch] <= avg[15] ? 0 : avg[14:3].
    - sampleValid<=1, sampleChannel<=ch.
    - Clear accumulator and count.
    - Advance adcChannel: ch==NUM_CHANNELS-1 wraps to 0.
    - -> TRIGGER.
- adcEnable is low for at least one full cycle (ACCUM) between conversions, so adc sees a fresh request edge.
- adcChannel changes only in PUBLISH, while adcEnable is low. It never changes during a conversion.
- Latency: PUBLISH follows the last sample's ready by 2 cycles. sampleValid is high exactly one cycle, the cycle after PUBLISH.
- Non-updated channels hold their previous values.
- No overflow is possible: accumulator width covers 2^AVG_LOG2 full-scale samples. -32768*16 fits in 20 signed bits.
- NUM_CHANNELS==1: adcChannel stays 0.

Optional Feature:
- Macro: ADC_SCAN_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in WAIT_START or WAIT_DONE and clears on every state change.
  - At TIMEOUT_CYCLES the block drops adcEnable, sets timeoutError=1 (sticky until reset), discards the current channel's partial accumulation and returns to TRIGGER on the same channel.
- Undefined: no counter logic; timeoutError constantly 0; the block waits indefinitely.

Decomposition:
- Package adc_scan_pkg:
  - state encodings TRIGGER=0, WAIT_START=1, WAIT_DONE=2, ACCUM=3, PUBLISH=4 (3-bit);
  - widths ADC_CODE_W=16 and VOLT_W=12.
- One sub-module, adc_sample_accumulator: signed accumulate/clear/shift-average datapath plus the negative-clamp voltage slice. The FSM stays in adc_channel_scanner.

Test Plan:
- Model adc: ready drops 3 cycles after enable and rises 20 cycles later with data. AVG_LOG2=0, ch0 data 16'h2000 -> rawAvg[0]=16'h2000, voltage[0]=12'h400, sampleValid pulse with sampleChannel=0, next conversion on adcChannel=1.
- AVG_LOG2=2, ch0 samples 100, 101, 102, 104 -> rawAvg[0]=101. No sampleValid before the 4th sample.
- Negative average: samples -8, -8, -8, -9 (AVG_LOG2=2) -> rawAvg=-9 (16'hFFF7) by floor shift, voltage=0.
- NUM_CHANNELS=3, run 3 publishes -> sampleChannel sequence 0, 1, 2, then adcChannel=0. adcEnable low ≥1 cycle between every conversion; adcChannel never toggles while adcEnable=1.
- Assert reset in WAIT_DONE -> adcEnable, sampleValid and all outputs 0 in the same cycle. After release, first publish is for ch0 and uses only post-reset samples.
- With ADC_SCAN_TIMEOUT_EN, TIMEOUT_CYCLES=50, model never drops ready -> timeoutError=1 at cycle 50 of WAIT_START, adcEnable drops, retry on the same channel. Flag stays set after later successful publishes.
